// File: rtl/imm_decode_stage.sv
// Decode stage for the shared immediate generator: derives IMM_SEL from the opcode,
// captures the generated immediate with the instruction, and buffers it in a 2-entry skid queue.
module imm_decode_stage #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      IN_INSTR,
    input  logic [31:0]      IN_PC,
    input  logic             FLUSH,
    output logic [24:0]      IMM_GEN_IN,
    output logic [2:0]       IMM_GEN_SEL,
    input  logic [31:0]      IMM_GEN_OUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [31:0]      OUT_INSTR,
    output logic [31:0]      OUT_PC,
    output logic [31:0]      OUT_IMM,
    output logic [2:0]       OUT_IMM_SEL,
    output logic             OUT_ILLEGAL,
    output logic [CNT_W-1:0] STALL_CNT
);

    localparam logic [2:0] SEL_NONE       = 3'd0;
    localparam logic [2:0] SEL_I_SIGNED   = 3'd1;
    localparam logic [2:0] SEL_I_UNSIGNED = 3'd2;
    localparam logic [2:0] SEL_I_SHIFT    = 3'd3;
    localparam logic [2:0] SEL_S          = 3'd4;
    localparam logic [2:0] SEL_B          = 3'd5;
    localparam logic [2:0] SEL_U          = 3'd6;
    localparam logic [2:0] SEL_J          = 3'd7;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  sel;
        logic        ill;
    } entry_t;

    state_t     state, state_nxt;
    entry_t     head, skid, new_entry;
    logic [2:0] dec_sel;
    logic       dec_ill;
    logic       push, pop;

    // Opcode decode: returns {illegal, imm_sel}
    function automatic logic [3:0] decode_op(input logic [6:0] op, input logic [2:0] funct3);
        logic [3:0] r;
        r = {1'b0, SEL_NONE};
        case (op)
            7'b0110111, 7'b0010111: r = {1'b0, SEL_U};
            7'b1101111:             r = {1'b0, SEL_J};
            7'b1100111, 7'b0000011: r = {1'b0, SEL_I_SIGNED};
            7'b1100011:             r = {1'b0, SEL_B};
            7'b0100011:             r = {1'b0, SEL_S};
            7'b0010011:             r = (funct3 == 3'b001 || funct3 == 3'b101) ?
                                        {1'b0, SEL_I_SHIFT} : {1'b0, SEL_I_SIGNED};
            7'b0110011, 7'b0001111, 7'b1110011: r = {1'b0, SEL_NONE};
            default:                r = {1'b1, SEL_NONE};
        endcase
        return r;
    endfunction

    always_comb begin
        {dec_ill, dec_sel} = decode_op(IN_INSTR[6:0], IN_INSTR[14:12]);
    end

    assign IMM_GEN_IN  = IN_INSTR[31:7];
    assign IMM_GEN_SEL = dec_sel;

    // Instructions without an immediate carry zero, whatever the generator drives for sel 0.
    always_comb begin
        new_entry.instr = IN_INSTR;
        new_entry.pc    = IN_PC;
        new_entry.imm   = (dec_sel == SEL_NONE) ? 32'd0 : IMM_GEN_OUT;
        new_entry.sel   = dec_sel;
        new_entry.ill   = dec_ill;
    end

    assign push = IN_VALID && IN_READY && !FLUSH;
    assign pop  = OUT_VALID && OUT_READY && !FLUSH;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (push) state_nxt = ST_ONE;
            ST_ONE: begin
                if (push && !pop)      state_nxt = ST_TWO;
                else if (pop && !push) state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (pop) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
        if (FLUSH) state_nxt = ST_EMPTY;
    end

    always_comb begin
        IN_READY  = (state != ST_TWO);
        OUT_VALID = (state != ST_EMPTY);
    end

    // Head reloads only on pop or on push into an empty queue; skid fills only from ONE.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (push && (state == ST_EMPTY || (state == ST_ONE && pop)))
                head <= new_entry;
            else if (pop && state == ST_TWO)
                head <= skid;
            if (push && state == ST_ONE && !pop)
                skid <= new_entry;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            STALL_CNT <= '0;
        else if (OUT_VALID && !OUT_READY && !FLUSH && STALL_CNT != {CNT_W{1'b1}})
            STALL_CNT <= STALL_CNT + 1'b1;
    end

    assign OUT_INSTR   = head.instr;
    assign OUT_PC      = head.pc;
    assign OUT_IMM     = head.imm;
    assign OUT_IMM_SEL = head.sel;
    assign OUT_ILLEGAL = head.ill;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: models the immediate generator, tracks accepted
// instructions in a FIFO scoreboard and checks scenario-specific behaviour inline.
module tb_imm_decode_stage;

    localparam int CNT_W = 4;
    localparam logic [2:0] SEL_NONE = 3'd0, SEL_IS = 3'd1, SEL_IU = 3'd2, SEL_SH = 3'd3;
    localparam logic [2:0] SEL_S = 3'd4, SEL_B = 3'd5, SEL_U = 3'd6, SEL_J = 3'd7;

    logic             CLK, RESET, IN_VALID, IN_READY, FLUSH, OUT_VALID, OUT_READY, OUT_ILLEGAL;
    logic [31:0]      IN_INSTR, IN_PC, IMM_GEN_OUT, OUT_INSTR, OUT_PC, OUT_IMM;
    logic [24:0]      IMM_GEN_IN;
    logic [2:0]       IMM_GEN_SEL, OUT_IMM_SEL;
    logic [CNT_W-1:0] STALL_CNT;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  sel;
        logic        ill;
    } exp_t;

    exp_t q[$];

    imm_decode_stage #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_INSTR(IN_INSTR), .IN_PC(IN_PC), .FLUSH(FLUSH),
        .IMM_GEN_IN(IMM_GEN_IN), .IMM_GEN_SEL(IMM_GEN_SEL), .IMM_GEN_OUT(IMM_GEN_OUT),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_INSTR(OUT_INSTR), .OUT_PC(OUT_PC),
        .OUT_IMM(OUT_IMM), .OUT_IMM_SEL(OUT_IMM_SEL), .OUT_ILLEGAL(OUT_ILLEGAL),
        .STALL_CNT(STALL_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Immediate generator model; sel 0 drives junk so the stage must zero it itself.
    function automatic logic [31:0] gen_model(input logic [31:0] i, input logic [2:0] sel);
        case (sel)
            SEL_IS:  return {{20{i[31]}}, i[31:20]};
            SEL_IU:  return {20'd0, i[31:20]};
            SEL_SH:  return {27'd0, i[24:20]};
            SEL_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            SEL_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            SEL_U:   return {i[31:12], 12'd0};
            SEL_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    assign IMM_GEN_OUT = gen_model({IMM_GEN_IN, 7'd0}, IMM_GEN_SEL);

    function automatic exp_t expect_of(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        e.instr = i;
        e.pc    = pc;
        e.ill   = 1'b0;
        e.sel   = SEL_NONE;
        case (i[6:0])
            7'h37, 7'h17: e.sel = SEL_U;
            7'h6F:        e.sel = SEL_J;
            7'h67, 7'h03: e.sel = SEL_IS;
            7'h63:        e.sel = SEL_B;
            7'h23:        e.sel = SEL_S;
            7'h13:        e.sel = (i[14:12] == 3'd1 || i[14:12] == 3'd5) ? SEL_SH : SEL_IS;
            7'h33, 7'h0F, 7'h73: e.sel = SEL_NONE;
            default:      e.ill = 1'b1;
        endcase
        e.imm = (e.sel == SEL_NONE) ? 32'd0 : gen_model(i, e.sel);
        return e;
    endfunction

    // Scoreboard: evaluated mid-cycle, describing what the coming rising edge does.
    always @(negedge CLK) begin
        if (!RESET || FLUSH) begin
            q.delete();
        end else begin
            if (OUT_VALID && OUT_READY) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got instr %h, required no output", OUT_INSTR);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if ({OUT_INSTR, OUT_PC, OUT_IMM, OUT_IMM_SEL, OUT_ILLEGAL} !== e) begin
                        bad++;
                        $display("FAIL sb_entry: got %h/%h/%h/%0d/%b required %h/%h/%h/%0d/%b",
                                 OUT_INSTR, OUT_PC, OUT_IMM, OUT_IMM_SEL, OUT_ILLEGAL,
                                 e.instr, e.pc, e.imm, e.sel, e.ill);
                    end
                end
            end
            if (IN_VALID && IN_READY) q.push_back(expect_of(IN_INSTR, IN_PC));
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        IN_VALID  = v;
        IN_INSTR  = i;
        IN_PC     = pc;
        OUT_READY = rdy;
        FLUSH     = fl;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        step();
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({OUT_VALID, OUT_INSTR, OUT_PC, OUT_IMM, OUT_IMM_SEL, OUT_ILLEGAL, STALL_CNT, IN_READY}
            !== {1'b0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, {CNT_W{1'b0}}, 1'b1}) begin
            bad++;
            $display("FAIL reset_state: got v=%b i=%h pc=%h imm=%h sel=%0d ill=%b cnt=%0d rdy=%b, required zeros with rdy=1",
                     OUT_VALID, OUT_INSTR, OUT_PC, OUT_IMM, OUT_IMM_SEL, OUT_ILLEGAL, STALL_CNT, IN_READY);
        end
    endtask

    task automatic test_decode();
        logic [31:0] ti [12] = '{32'hFFF00093, 32'h123452B7, 32'hFE000EE3, 32'h01F09093,
                                 32'h00112223, 32'hFFFFFFFF, 32'h002081B3, 32'h0080006F,
                                 32'hFFF0B093, 32'h0000000F, 32'h00000073, 32'h4050D093};
        logic [31:0] tm [12] = '{32'hFFFFFFFF, 32'h12345000, 32'hFFFFFFFC, 32'h0000001F,
                                 32'h00000004, 32'h00000000, 32'h00000000, 32'h00000008,
                                 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000005};
        logic [2:0]  ts [12] = '{SEL_IS, SEL_U, SEL_B, SEL_SH, SEL_S, SEL_NONE, SEL_NONE, SEL_J,
                                 SEL_IS, SEL_NONE, SEL_NONE, SEL_SH};
        logic        tl [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, ti[k], 32'h1000 + 32'(4 * k), 1'b1, 1'b0);
            step();
            total++;
            if ({OUT_VALID, OUT_INSTR, OUT_IMM, OUT_IMM_SEL, OUT_ILLEGAL}
                !== {1'b1, ti[k], tm[k], ts[k], tl[k]}) begin
                bad++;
                $display("FAIL decode_%0d: got v=%b i=%h imm=%h sel=%0d ill=%b required v=1 i=%h imm=%h sel=%0d ill=%b",
                         k, OUT_VALID, OUT_INSTR, OUT_IMM, OUT_IMM_SEL, OUT_ILLEGAL,
                         ti[k], tm[k], ts[k], tl[k]);
            end
        end
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a = 32'h00A00093, b = 32'h12345237, c = 32'h00112223;
        do_reset();
        drive(1'b1, a, 32'h2000, 1'b0, 1'b0); step();
        total++;
        if ({OUT_VALID, OUT_INSTR, IN_READY} !== {1'b1, a, 1'b1}) begin
            bad++; $display("FAIL b2b_first: got v=%b i=%h rdy=%b required 1 %h 1", OUT_VALID, OUT_INSTR, IN_READY, a);
        end
        drive(1'b1, b, 32'h2004, 1'b0, 1'b0); step();
        total++;
        if ({IN_READY, OUT_INSTR, STALL_CNT} !== {1'b0, a, 4'd1}) begin
            bad++; $display("FAIL b2b_full: got rdy=%b i=%h cnt=%0d required 0 %h 1", IN_READY, OUT_INSTR, STALL_CNT, a);
        end
        drive(1'b1, c, 32'h2008, 1'b0, 1'b0); step();
        total++;
        if ({IN_READY, OUT_INSTR, STALL_CNT} !== {1'b0, a, 4'd2}) begin
            bad++; $display("FAIL b2b_hold: got rdy=%b i=%h cnt=%0d required 0 %h 2", IN_READY, OUT_INSTR, STALL_CNT, a);
        end
        step();
        total++;
        if (STALL_CNT !== 4'd3) begin
            bad++; $display("FAIL b2b_stall3: got %0d required 3", STALL_CNT);
        end
        OUT_READY = 1'b1; step();
        total++;
        if ({OUT_VALID, OUT_INSTR} !== {1'b1, b}) begin
            bad++; $display("FAIL b2b_pop_b: got v=%b i=%h required 1 %h", OUT_VALID, OUT_INSTR, b);
        end
        step();
        total++;
        if ({OUT_VALID, OUT_INSTR} !== {1'b1, c}) begin
            bad++; $display("FAIL b2b_pop_c: got v=%b i=%h required 1 %h", OUT_VALID, OUT_INSTR, c);
        end
        IN_VALID = 1'b0; step();
        total++;
        if ({OUT_VALID, STALL_CNT} !== {1'b0, 4'd3}) begin
            bad++; $display("FAIL b2b_drain: got v=%b cnt=%0d required 0 3", OUT_VALID, STALL_CNT);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 32'h00100093, 32'h3000, 1'b0, 1'b0); step();
        drive(1'b1, 32'h00200093, 32'h3004, 1'b0, 1'b0); step();
        drive(1'b1, 32'h00300093, 32'h3008, 1'b0, 1'b1); step();
        total++;
        if ({OUT_VALID, IN_READY, STALL_CNT} !== {1'b0, 1'b1, 4'd1}) begin
            bad++; $display("FAIL flush_two: got v=%b rdy=%b cnt=%0d required 0 1 1", OUT_VALID, IN_READY, STALL_CNT);
        end
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0); step(); step();
        total++;
        if (OUT_VALID !== 1'b0) begin
            bad++; $display("FAIL flush_absent: got v=%b required 0", OUT_VALID);
        end
        drive(1'b1, 32'h00400093, 32'h300C, 1'b1, 1'b0); step();
        drive(1'b1, 32'h00500093, 32'h3010, 1'b1, 1'b1); step();
        total++;
        if (OUT_VALID !== 1'b0) begin
            bad++; $display("FAIL flush_one: got v=%b required 0", OUT_VALID);
        end
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0); step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, 32'hFFFFFFFF, 32'h4000, 1'b0, 1'b0); step();
        drive(1'b1, 32'h123452B7, 32'h4004, 1'b0, 1'b0); step();
        step();
        #2 RESET = 1'b0;
        #1;
        total++;
        if ({OUT_VALID, OUT_INSTR, OUT_PC, OUT_IMM, OUT_IMM_SEL, OUT_ILLEGAL, STALL_CNT, IN_READY}
            !== {1'b0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, {CNT_W{1'b0}}, 1'b1}) begin
            bad++;
            $display("FAIL reset_mid: got v=%b i=%h pc=%h imm=%h sel=%0d ill=%b cnt=%0d rdy=%b, required zeros with rdy=1",
                     OUT_VALID, OUT_INSTR, OUT_PC, OUT_IMM, OUT_IMM_SEL, OUT_ILLEGAL, STALL_CNT, IN_READY);
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        RESET = 1'b1;
        step();
        total++;
        if (OUT_VALID !== 1'b0) begin
            bad++; $display("FAIL reset_mid_after: got v=%b required 0", OUT_VALID);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        drive(1'b1, 32'hFFF00093, 32'h5000, 1'b0, 1'b0); step();
        IN_VALID = 1'b0;
        for (int k = 0; k < 10; k++) step();
        total++;
        if (STALL_CNT !== 4'd10) begin
            bad++; $display("FAIL stall_mid: got %0d required 10", STALL_CNT);
        end
        for (int k = 10; k < (1 << CNT_W) + 5; k++) step();
        total++;
        if (STALL_CNT !== 4'hF) begin
            bad++; $display("FAIL stall_sat: got %0d required 15", STALL_CNT);
        end
        OUT_READY = 1'b1; step();
        total++;
        if ({OUT_VALID, STALL_CNT} !== {1'b0, 4'hF}) begin
            bad++; $display("FAIL stall_hold: got v=%b cnt=%0d required 0 15", OUT_VALID, STALL_CNT);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h63,
                                 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};
        logic [31:0] w;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            w = $urandom;
            w[6:0] = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 11)];
            drive(1'($urandom_range(0, 3) != 0), w, 32'h8000 + 32'(4 * k),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
            step();
        end
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step();
        total++;
        if (OUT_VALID !== 1'b0 || q.size() != 0) begin
            bad++; $display("FAIL random_drain: got v=%b pending=%0d required 0 0", OUT_VALID, q.size());
        end
    endtask

    initial begin
        RESET = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
